// File: rtl/mlp_result_packer_if.sv
// Result/FIFO-write bundle between the MLP output layer,
// the result packer and axis_master.
interface mlp_result_packer_if #(
  parameter int DW = 32,
  parameter int RW = 16
);
  logic [RW-1:0] pi_result_data;
  logic          pi_result_valid;
  logic          pi_result_last;
  logic          po_result_ready;
  logic [DW-1:0] po_mlp_data;
  logic          po_write_to_fifo;
  logic          pi_wr_fifo_done;
  logic          po_frame_overflow;
  logic          po_busy;

  modport slave (
    input  pi_result_data,
    input  pi_result_valid,
    input  pi_result_last,
    input  pi_wr_fifo_done,
    output po_result_ready,
    output po_mlp_data,
    output po_write_to_fifo,
    output po_frame_overflow,
    output po_busy
  );

  modport master (
    output pi_result_data,
    output pi_result_valid,
    output pi_result_last,
    output pi_wr_fifo_done,
    input  po_result_ready,
    input  po_mlp_data,
    input  po_write_to_fifo,
    input  po_frame_overflow,
    input  po_busy
  );
endinterface

// File: rtl/mlp_result_packer.sv
// Packs MLP results into words, buffers a frame, flushes it to axis_master.
// Optional MLP_RESULT_ARGMAX_EN appends the argmax index word to each frame.
module mlp_result_packer #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int RESULT_WIDTH         = 16,
  parameter int MAX_WORDS            = 16
) (
  input logic                pi_clk,
  input logic                pi_rst,
  mlp_result_packer_if.slave bus
);
  localparam int DW    = C_M_AXIS_TDATA_WIDTH;
  localparam int RW    = RESULT_WIDTH;
  localparam int LANES = DW / RW;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW    = $clog2(MAX_WORDS);
  localparam int CW    = AW + 1;

  typedef enum logic [1:0] {
    COLLECT   = 2'd0,
    FLUSH     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [LW-1:0]  lane_q, lane_d;
  logic [CW-1:0]  wcnt_q, wcnt_d;
  logic [CW-1:0]  rd_q, rd_d;
  logic [DW-1:0]  word_q, word_d;
  logic           ovf_q, ovf_d;
  logic [DW-1:0]  buf_q [MAX_WORDS];

  logic          st_col, st_fl, st_wt;
  logic          acc, last, lane_full, commit;
  logic          ovf_hit, done_hit, flush_end;
  logic [CW-1:0] flush_n;
  logic [DW-1:0] word_ins;

  assign st_col    = (state_q == COLLECT);
  assign st_fl     = (state_q == FLUSH);
  assign st_wt     = (state_q == WAIT_DONE);
  assign acc       = bus.pi_result_valid & bus.po_result_ready;
  assign last      = bus.pi_result_last;
  assign lane_full = (lane_q == LW'(LANES - 1));
  assign commit    = acc & (lane_full | last);
  assign ovf_hit   = commit & ~last
                   & (wcnt_q == CW'(MAX_WORDS - 1));
  assign done_hit  = st_wt & bus.pi_wr_fifo_done;
  assign flush_end = (rd_q == flush_n - 1'b1);

  // Insert the incoming result into its lane of the partial word.
  always_comb begin
    word_ins = word_q;
    for (int k = 0; k < LANES; k++) begin
      if (lane_q == LW'(k)) begin
        word_ins[k*RW +: RW] = bus.pi_result_data;
      end
    end
  end

`ifdef MLP_RESULT_ARGMAX_EN
  localparam int IW = $clog2(MAX_WORDS * LANES) + 1;

  logic signed [RW-1:0] max_q, max_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        best_q, best_d;

  assign flush_n = wcnt_q + 1'b1;

  // Running signed maximum; strict compare keeps the lowest index on ties.
  always_comb begin
    max_d  = max_q;
    idx_d  = idx_q;
    best_d = best_q;
    if (acc) begin
      idx_d = idx_q + 1'b1;
      if ((idx_q == '0)
          || ($signed(bus.pi_result_data) > max_q)) begin
        max_d  = bus.pi_result_data;
        best_d = idx_q;
      end
    end
    if (done_hit) begin
      max_d  = '0;
      idx_d  = '0;
      best_d = '0;
    end
  end

  // Argmax tracking registers, restarted with each frame.
  always_ff @(posedge pi_clk) begin
    if (pi_rst) begin
      max_q  <= '0;
      idx_q  <= '0;
      best_q <= '0;
    end else begin
      max_q  <= max_d;
      idx_q  <= idx_d;
      best_q <= best_d;
    end
  end
`else
  assign flush_n = wcnt_q;
`endif

  // Lane/word bookkeeping, flush read pointer and sticky overflow.
  always_comb begin
    lane_d = lane_q;
    wcnt_d = wcnt_q;
    word_d = word_q;
    rd_d   = st_fl ? rd_q + 1'b1 : '0;
    ovf_d  = ovf_q | ovf_hit;
    if (acc) begin
      if (lane_full | last) begin
        lane_d = '0;
        word_d = '0;
        wcnt_d = wcnt_q + 1'b1;
      end else begin
        lane_d = lane_q + 1'b1;
        word_d = word_ins;
      end
    end
    if (done_hit) begin
      lane_d = '0;
      wcnt_d = '0;
    end
  end

  // Datapath registers; reset aborts any frame in progress.
  always_ff @(posedge pi_clk) begin
    if (pi_rst) begin
      lane_q <= '0;
      wcnt_q <= '0;
      word_q <= '0;
      rd_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      lane_q <= lane_d;
      wcnt_q <= wcnt_d;
      word_q <= word_d;
      rd_q   <= rd_d;
      ovf_q  <= ovf_d;
    end
  end

  // Frame buffer; contents are don't-care after reset.
  always_ff @(posedge pi_clk) begin
    if (commit) begin
      buf_q[wcnt_q[AW-1:0]] <= word_ins;
    end
  end

  // FSM state register.
  always_ff @(posedge pi_clk) begin
    if (pi_rst) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  // FSM next-state: frame end or truncation starts the flush.
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      st_col: if (acc & (last | ovf_hit)) state_d = FLUSH;
      st_fl:  if (flush_end) state_d = WAIT_DONE;
      st_wt:  if (bus.pi_wr_fifo_done) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // FSM outputs: strobe and data are driven straight from state.
  always_comb begin
    bus.po_result_ready   = st_col
                          & (wcnt_q < CW'(MAX_WORDS));
    bus.po_write_to_fifo  = st_fl;
    bus.po_busy           = st_fl | st_wt;
    bus.po_frame_overflow = ovf_q;
    bus.po_mlp_data       = '0;
    if (st_fl) begin
      bus.po_mlp_data = buf_q[rd_q[AW-1:0]];
`ifdef MLP_RESULT_ARGMAX_EN
      if (rd_q == wcnt_q) bus.po_mlp_data = DW'(best_q);
`endif
    end
  end
endmodule
